// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter shared definitions.
// State encoding, requester count, pick result and counter width helper.
package mux4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } pick_t;

    function automatic int hold_w(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter request/data/grant bundle.
// master drives requests and data; slave is the arbiter.
interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]    req;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;
    logic [DW-1:0] din3;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          valid;
    logic [DW-1:0] dout;

    modport master (
        output req, din0, din1, din2, din3,
        input  gnt, sel, valid, dout
    );

    modport slave (
        input  req, din0, din1, din2, din3,
        output gnt, sel, valid, dout
    );
endinterface

// File: rtl/mux4_rr_arbiter_mux4to1_dw.sv
// Plain DW-wide 4:1 combinational mux.
// Used as the shared datapath steered by the arbiter select.
module mux4to1_dw #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] in3,
    input  logic [1:0]    sel,
    output logic [DW-1:0] out
);

    // steer the selected input to the output
    always_comb begin
        out = in0;
        unique case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded tenure driving a shared 4:1 mux.
// Grant and select are registered; dout is gated by valid.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_arbiter_if.slave bus
);

    localparam int HW = hold_w(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [3:0]    gnt_q,   gnt_d;
    logic [1:0]    sel_q,   sel_d;
    logic [1:0]    ptr_q,   ptr_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic          rearb;
    pick_t         win;
    logic [DW-1:0] mux_out;
    logic          valid;

    function automatic pick_t rr_pick(
        input logic [3:0] r,
        input logic [1:0] p
    );
        pick_t      res;
        logic [1:0] c;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = p + 2'(k);
            if (r[c]) begin
                res.hit = 1'b1;
                res.idx = c;
            end
        end
        return res;
    endfunction

    // next-state: grant on idle, release, or tenure expiry
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        rearb   = 1'b0;
        win     = rr_pick(bus.req, ptr_q);
        unique case (state_q)
            ST_IDLE: begin
                if (win.hit) rearb = 1'b1;
            end
            ST_BUSY: begin
                if (!bus.req[sel_q]) begin
                    if (win.hit) begin
                        rearb = 1'b1;
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    rearb = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: ;
        endcase
        if (rearb) begin
            gnt_d   = 4'b0001 << win.idx;
            sel_d   = win.idx;
            ptr_d   = win.idx + 2'd1;
            state_d = ST_BUSY;
            hold_d  = '0;
        end
    end

    // arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    mux4to1_dw #(
        .DW (DW)
    ) u_mux (
        .in0 (bus.din0),
        .in1 (bus.din1),
        .in2 (bus.din2),
        .in3 (bus.din3),
        .sel (sel_q),
        .out (mux_out)
    );

    assign valid     = |gnt_q;
    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid;
    assign bus.dout  = valid ? mux_out : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter (MAX_HOLD=4 and MAX_HOLD=1).
// A tenure-counting reference model feeds a queue drained by a monitor.
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] din [4];

    int errors = 0;
    int checks = 0;

    exp_t sq [2][$];
    int   own  [2] = '{-1, -1};
    int   ten  [2] = '{0, 0};
    int   mptr [2] = '{0, 0};
    int   msel [2] = '{0, 0};
    int   mh   [2] = '{4, 1};

    logic [3:0] g [2];
    logic [1:0] s [2];
    logic       v [2];
    logic [7:0] o [2];

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.DW(8)) ifa ();
    mux4_rr_arbiter_if #(.DW(8)) ifb ();

    assign ifa.req  = req;
    assign ifa.din0 = din[0];
    assign ifa.din1 = din[1];
    assign ifa.din2 = din[2];
    assign ifa.din3 = din[3];
    assign ifb.req  = req;
    assign ifb.din0 = din[0];
    assign ifb.din1 = din[1];
    assign ifb.din2 = din[2];
    assign ifb.din3 = din[3];

    assign g[0] = ifa.gnt;
    assign s[0] = ifa.sel;
    assign v[0] = ifa.valid;
    assign o[0] = ifa.dout;
    assign g[1] = ifb.gnt;
    assign s[1] = ifb.sel;
    assign v[1] = ifb.valid;
    assign o[1] = ifb.dout;

    mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    mux4_rr_arbiter #(.DW(8), .MAX_HOLD(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: owner + tenure count, round-robin pointer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                own[d]  = -1;
                ten[d]  = 0;
                mptr[d] = 0;
                msel[d] = 0;
                sq[d].delete();
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit   need;
                bit   found;
                int   w;
                int   c;
                exp_t e;
                need = 1'b0;
                if (own[d] < 0) need = 1'b1;
                else if (!req[own[d]]) need = 1'b1;
                else if (ten[d] == mh[d]) need = 1'b1;
                else ten[d] = ten[d] + 1;
                if (need) begin
                    found = 1'b0;
                    w = -1;
                    for (int k = 0; k < 4; k++) begin
                        c = (mptr[d] + k) % 4;
                        if (!found && req[c]) begin
                            found = 1'b1;
                            w = c;
                        end
                    end
                    if (found) begin
                        own[d]  = w;
                        ten[d]  = 1;
                        mptr[d] = (w + 1) % 4;
                        msel[d] = w;
                    end else begin
                        own[d] = -1;
                        ten[d] = 0;
                    end
                end
                e.gnt = (own[d] < 0) ? 4'b0000 : 4'(1 << own[d]);
                e.sel = 2'(msel[d]);
                sq[d].push_back(e);
            end
        end
    end

    // monitor: compare presented outputs against queued expectations
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk($sformatf("rst_gnt%0d", d), 32'(g[d]), 32'h0);
                chk($sformatf("rst_valid%0d", d), 32'(v[d]), 32'h0);
                chk($sformatf("rst_dout%0d", d), 32'(o[d]), 32'h0);
            end else if (sq[d].size() == 0) begin
                chk($sformatf("sb_empty%0d", d), 32'(sq[d].size()), 32'h1);
            end else begin
                exp_t e;
                logic [7:0] ed;
                logic       ev;
                e  = sq[d].pop_front();
                ev = |e.gnt;
                ed = ev ? din[e.sel] : 8'h00;
                chk($sformatf("gnt%0d", d), 32'(g[d]), 32'(e.gnt));
                chk($sformatf("sel%0d", d), 32'(s[d]), 32'(e.sel));
                chk($sformatf("valid%0d", d), 32'(v[d]), 32'(ev));
                chk($sformatf("dout%0d", d), 32'(o[d]), 32'(ed));
                chk($sformatf("onehot%0d", d), 32'($onehot0(g[d])), 32'h1);
                chk($sformatf("gnt_sel%0d", d), 32'(g[d][s[d]]), 32'(v[d]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e4;
        rst_n = 1'b0;
        req   = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        req    = 4'b0100;
        din[2] = 8'hA5;
        chk("pre_gnt", 32'(g[0]), 32'h0);
        chk("pre_dout", 32'(o[0]), 32'h0);
        @(posedge clk); #1;
        chk("t1_gnt", 32'(g[0]), 32'h4);
        chk("t1_sel", 32'(s[0]), 32'h2);
        chk("t1_valid", 32'(v[0]), 32'h1);
        chk("t1_dout", 32'(o[0]), 32'hA5);

        @(negedge clk); req = 4'b0000;
        @(negedge clk); req = 4'b0011;
        @(posedge clk); #1;
        chk("b2b_first", 32'(g[0]), 32'h1);
        @(negedge clk); req = 4'b0010;
        @(posedge clk); #1;
        chk("b2b_second", 32'(g[0]), 32'h2);
        chk("b2b_valid", 32'(v[0]), 32'h1);
        @(negedge clk); req = 4'b0000;
        @(posedge clk); #1;
        chk("b2b_idle", 32'(g[0]), 32'h0);
        chk("b2b_idle_v", 32'(v[0]), 32'h0);

        @(negedge clk); req = 4'b0001;
        @(posedge clk); #1;
        chk("to_hold0", 32'(g[0]), 32'h1);
        @(negedge clk); req = 4'b1001;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("to_hold%0d", i), 32'(g[0]), 32'h1);
        end
        @(posedge clk); #1;
        chk("to_switch", 32'(g[0]), 32'h8);
        @(negedge clk); req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("solo_hold", 32'(g[0]), 32'h1);
        end

        @(negedge clk); req = 4'b0100;
        @(posedge clk); #1;
        chk("ar_pre_a", 32'(g[0]), 32'h4);
        chk("ar_pre_b", 32'(g[1]), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ar_gnt%0d", d), 32'(g[d]), 32'h0);
            chk($sformatf("ar_valid%0d", d), 32'(v[d]), 32'h0);
            chk($sformatf("ar_dout%0d", d), 32'(o[d]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            e4 = 4'b0001 << (i % 4);
            chk($sformatf("rr_seq%0d", i), 32'(g[1]), 32'(e4));
            if (i == 0) chk("ar_first_a", 32'(g[0]), 32'h1);
        end

        @(negedge clk); req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        #1 req = 4'b0010;
        #2 req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("spur_a", 32'(g[0]), 32'h0);
            chk("spur_b", 32'(g[1]), 32'h0);
        end

        repeat (10000) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                din[i] = 8'($urandom);
            end
        end

        @(negedge clk); req = 4'b0000;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux between four requesters.
- Registers a one-hot grant and the matching 2-bit mux select, then steers the granted requester's data to a single output.
- A hold counter bounds grant tenure so no requester can starve the others.
- Sits in front of the existing 4:1 mux datapath as its sequencing and select controller.

Parameters:
- DW, 8, data width of each input and of the output.
- MAX_HOLD, 4, maximum consecutive cycles one grant is held while others request; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; req[i] stays high for as long as requester i wants the mux.
- din0  input  DW  requester 0 data.
- din1  input  DW  requester 1 data.
- din2  input  DW  requester 2 data.
- din3  input  DW  requester 3 data.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  registered mux select; equals the index of the set gnt bit.
- valid  output  1  high when gnt is non-zero.
- dout  output  DW  data input selected by sel when valid; zero when not valid.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=4'b0000, sel=2'b00, valid=0, dout=0.
  - state=IDLE, hold_cnt=0, rr pointer ptr=2'd0, so req[0] has top priority after reset.
  - Takes effect immediately, including mid-grant.
  - First arbitration occurs on the first rising edge after rst_n deasserts.
- Round-robin pick:
  - Search req starting at index ptr, ascending modulo 4; the first set bit wins.
  - On every new grant, ptr <= winner+1 (mod 4).
- State IDLE:
  - req==0: remain IDLE, gnt=0.
  - req!=0 at edge N: gnt/sel are loaded at edge N, so they are visible in the cycle after req is first sampled (1-cycle latency). state <= BUSY, hold_cnt <= 0.
- State BUSY (owner = sel). Evaluated each edge:
  - req[sel]=0 (release): re-arbitrate the same edge.
    - Another req is set: new grant, back-to-back with no idle cycle, hold_cnt <= 0.
    - Otherwise: gnt <= 0, state <= IDLE.
  - req[sel]=1 and hold_cnt==MAX_HOLD-1 (timeout): re-arbitrate starting at ptr (= owner+1), so the owner has lowest priority.
    - Another req is set: that requester wins.
    - Otherwise: the owner is re-granted, gnt is unchanged, hold_cnt <= 0.
  - Else: hold grant, hold_cnt <= hold_cnt+1.
  - req bits of non-owners never preempt before timeout.
- hold_cnt:
  - Width is $clog2(MAX_HOLD), minimum 1 bit.
  - Saturation is never reached because timeout resets it.
  - MAX_HOLD=1: re-arbitrate every cycle, giving pure per-cycle round robin.
- Output invariants:
  - gnt is always zero or one-hot.
  - sel is held at the last value when idle (don't-care).
  - valid = |gnt.
  - dout is combinational from registered sel and din*, then gated by valid.
- Simultaneous events: release and timeout in the same cycle are treated as release.
- Invariants are checkable by assertion:
  - One-hot gnt.
  - gnt[sel]==valid.
  - No grant to a requester whose req was low at the granting edge.

Decomposition:
- Shared package:
  - State encoding constants: ST_IDLE=1'b0, ST_BUSY=1'b1.
  - NUM_REQ=4.
  - Width helper for hold_cnt.
- One sub-module: mux4to1_dw, a DW-parameterised 4:1 combinational mux with ports out, in0..in3, sel[1:0]. It is instantiated once for dout ahead of the valid gate.
- The round-robin pick is a function inside the arbiter, not a separate module.

Test Plan:
- Reset and single request: rst_n low 3 cycles, then req=4'b0100, din2=8'hA5 -> the cycle after first sample, gnt=4'b0100, sel=2, valid=1, dout=8'hA5. Before that, gnt=0 and dout=0.
- Round-robin fairness: MAX_HOLD=1, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Release back-to-back: req=4'b0011; after gnt=0001, drop req[0] -> the next cycle gnt=0010 with no cycle of valid=0. Then drop req[1] -> gnt=0000, valid=0.
- Timeout: MAX_HOLD=4, req[0] held high, req[3] raised one cycle after gnt=0001 -> gnt=0001 for exactly 4 cycles, then gnt=1000. With only req[0] high, gnt stays 0001 indefinitely.
- Async reset mid-grant: gnt=0100 and rst_n pulsed low between edges -> gnt=0, valid=0, dout=0 immediately, without waiting for a clock edge. After release with req=4'b1111, the first grant is 0001.
- No spurious grant: req pulse 4'b0010 for less than one cycle between edges -> gnt stays 0000. One-hot and gnt[sel]==valid assertions hold across 10k cycles of random req.
